// File: rtl/n64a_vtiming_mon.sv
// rtl/n64a_vtiming_mon.sv - N64 sync-timing monitor: line length, field lines, PAL/480i detection and lock
module n64a_vtiming_mon #(
  parameter int HTIMEOUT = 4095,
  parameter int VTIMEOUT = 1023,
  parameter int PAL_TH   = 288,
  parameter int VL_MIN   = 200,
  parameter int VL_MAX   = 330
) (
  input  logic        VCLK,
  input  logic        nVRST_Tx,
  input  logic        nVDSYNC,
  input  logic [3:0]  Sync_i,
  output logic [11:0] line_len,
  output logic [9:0]  field_lines,
  output logic        field_id,
  output logic        pal_mode,
  output logic        n64_480i,
  output logic        timing_valid,
  output logic        new_field
);

  localparam logic [11:0] HTO   = 12'(HTIMEOUT);
  localparam logic [9:0]  VTO   = 10'(VTIMEOUT);
  localparam logic [9:0]  PALTH = 10'(PAL_TH);
  localparam logic [9:0]  VLMIN = 10'(VL_MIN);
  localparam logic [9:0]  VLMAX = 10'(VL_MAX);

  typedef enum logic [1:0] {NOLOCK, ARMED, LOCKED} lock_e;

  lock_e       state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [11:0] line_len_q, line_len_d;
  logic [11:0] ref_len_q, ref_len_d;
  logic [9:0]  field_lines_q, field_lines_d;
  logic        field_id_q, field_id_d;
  logic        prev_par_q, prev_par_d;
  logic [1:0]  icnt_q, icnt_d;
  logic [1:0]  pcnt_q, pcnt_d;
  logic        ilace_q, ilace_d;
  logic        pal_mode_q, pal_mode_d;
  logic        n64_480i_q, n64_480i_d;
  logic        timing_valid_q, timing_valid_d;
  logic        new_field_q, new_field_d;

  logic        smp, hfall, vfall, par, in_win, jump;
  logic [1:0]  cur;
  logic [11:0] dlen;
  logic        unused_sync;

  assign unused_sync = Sync_i[2] ^ Sync_i[0];

  always_comb begin
    smp   = !nVDSYNC;
    cur   = {Sync_i[3], Sync_i[1]};
    hfall = smp & sync_q[0] & ~cur[0];
    vfall = smp & sync_q[1] & ~cur[1];
    par    = 1'b0;
    in_win = 1'b0;
    jump   = 1'b0;
    dlen   = '0;

    state_d        = state_q;
    sync_d         = sync_q;
    hcnt_d         = hcnt_q;
    vcnt_d         = vcnt_q;
    line_len_d     = line_len_q;
    ref_len_d      = ref_len_q;
    field_lines_d  = field_lines_q;
    field_id_d     = field_id_q;
    prev_par_d     = prev_par_q;
    icnt_d         = icnt_q;
    pcnt_d         = pcnt_q;
    ilace_d        = ilace_q;
    new_field_d    = vfall;

    if (smp) begin
      sync_d = cur;
      if (hfall) begin
        line_len_d = hcnt_q + 12'd1;
        hcnt_d     = '0;
        vcnt_d     = (vcnt_q == VTO) ? vcnt_q : vcnt_q + 10'd1;
      end else if (hcnt_q != HTO) begin
        hcnt_d = hcnt_q + 12'd1;
      end

      if (vfall) begin
        field_lines_d = vcnt_q;
        vcnt_d        = hfall ? 10'd1 : 10'd0;
        // A coincident hsync fall means the counter sits at line end, so parity is even.
        par           = !hfall && (hcnt_q >= {1'b0, line_len_q[11:1]});
        field_id_d    = par;
        prev_par_d    = par;
        if (par != prev_par_q) begin
          icnt_d = (icnt_q == 2'd3) ? 2'd3 : icnt_q + 2'd1;
          pcnt_d = '0;
          if (icnt_d >= 2'd2) ilace_d = 1'b1;
        end else begin
          pcnt_d = (pcnt_q == 2'd3) ? 2'd3 : pcnt_q + 2'd1;
          icnt_d = '0;
          if (pcnt_d >= 2'd2) ilace_d = 1'b0;
        end

        in_win = (vcnt_q >= VLMIN) && (vcnt_q <= VLMAX);
        case (state_q)
          NOLOCK: begin
            if (in_win) begin
              state_d   = ARMED;
              ref_len_d = line_len_d;
            end
          end
          ARMED:   state_d = (in_win && line_len_d == ref_len_q) ? LOCKED : NOLOCK;
          LOCKED:  if (!in_win) state_d = NOLOCK;
          default: state_d = NOLOCK;
        endcase
      end

      // Line length may wander by one sample while locked; anything more is a new source.
      if (hfall && state_q == LOCKED) begin
        dlen = line_len_d - line_len_q;
        jump = !(dlen == 12'd0 || dlen == 12'd1 || dlen == 12'hFFF);
        if (jump) state_d = NOLOCK;
      end

      if (hcnt_d == HTO || vcnt_d == VTO) state_d = NOLOCK;
    end

    timing_valid_d = (state_d == LOCKED);
    pal_mode_d     = (state_d == LOCKED) ? (field_lines_d >= PALTH) : pal_mode_q;
    n64_480i_d     = (state_d == LOCKED) ? ilace_d : n64_480i_q;
  end

  always_ff @(posedge VCLK or negedge nVRST_Tx) begin
    if (!nVRST_Tx) begin
      state_q        <= NOLOCK;
      sync_q         <= 2'b11;
      hcnt_q         <= '0;
      vcnt_q         <= '0;
      line_len_q     <= '0;
      ref_len_q      <= '0;
      field_lines_q  <= '0;
      field_id_q     <= 1'b0;
      prev_par_q     <= 1'b0;
      icnt_q         <= '0;
      pcnt_q         <= '0;
      ilace_q        <= 1'b0;
      pal_mode_q     <= 1'b0;
      n64_480i_q     <= 1'b0;
      timing_valid_q <= 1'b0;
      new_field_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      hcnt_q         <= hcnt_d;
      vcnt_q         <= vcnt_d;
      line_len_q     <= line_len_d;
      ref_len_q      <= ref_len_d;
      field_lines_q  <= field_lines_d;
      field_id_q     <= field_id_d;
      prev_par_q     <= prev_par_d;
      icnt_q         <= icnt_d;
      pcnt_q         <= pcnt_d;
      ilace_q        <= ilace_d;
      pal_mode_q     <= pal_mode_d;
      n64_480i_q     <= n64_480i_d;
      timing_valid_q <= timing_valid_d;
      new_field_q    <= new_field_d;
    end
  end

  assign line_len     = line_len_q;
  assign field_lines  = field_lines_q;
  assign field_id     = field_id_q;
  assign pal_mode     = pal_mode_q;
  assign n64_480i     = n64_480i_q;
  assign timing_valid = timing_valid_q;
  assign new_field    = new_field_q;

endmodule

// File: tb/tb_n64a_vtiming_mon.sv
// tb/tb_n64a_vtiming_mon.sv - directed bench for n64a_vtiming_mon on a scaled-down video raster
module tb_n64a_vtiming_mon;

  localparam int LEN = 13;

  logic        VCLK = 1'b0;
  logic        nVRST_Tx = 1'b0;
  logic        nVDSYNC = 1'b1;
  logic [3:0]  Sync_i = 4'hF;
  logic [11:0] line_len;
  logic [9:0]  field_lines;
  logic        field_id, pal_mode, n64_480i, timing_valid, new_field;

  int checks = 0;
  int errors = 0;
  int gap = 1;
  int vf_tv, vf_fid, vf_pal, vf_i, vf_fl;
  int nf_run = 0, nf_width = 0, nf_cnt = 0;

  n64a_vtiming_mon #(
    .HTIMEOUT(100), .VTIMEOUT(60), .PAL_TH(18), .VL_MIN(8), .VL_MAX(24)
  ) dut (
    .VCLK(VCLK), .nVRST_Tx(nVRST_Tx), .nVDSYNC(nVDSYNC), .Sync_i(Sync_i),
    .line_len(line_len), .field_lines(field_lines), .field_id(field_id),
    .pal_mode(pal_mode), .n64_480i(n64_480i), .timing_valid(timing_valid),
    .new_field(new_field)
  );

  always #5 VCLK = ~VCLK;

  always @(negedge VCLK) begin
    if (new_field) nf_run = nf_run + 1;
    else if (nf_run != 0) begin
      nf_width = nf_run;
      nf_cnt   = nf_cnt + 1;
      nf_run   = 0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic smp(input logic v, input logic h);
    nVDSYNC = 1'b0;
    Sync_i  = {v, 1'b1, h, 1'b1};
    @(posedge VCLK); #1;
    nVDSYNC = 1'b1;
    Sync_i  = 4'hF;
    if (!v) begin
      vf_tv = timing_valid; vf_fid = field_id; vf_pal = pal_mode;
      vf_i  = n64_480i;     vf_fl  = field_lines;
    end
    repeat (gap - 1) begin @(posedge VCLK); #1; end
  endtask

  // hsync falls on sample 0; vsync falls on sample vk (-1: none)
  task automatic line(input int len, input int vk);
    for (int k = 0; k < len; k++) smp(!(k == vk), !(k == 0));
  endtask

  task automatic lines(input int n);
    repeat (n) line(LEN, -1);
  endtask

  task automatic do_reset;
    nVRST_Tx = 1'b0;
    #5;
    nVRST_Tx = 1'b1;
    @(posedge VCLK); #1;
  endtask

  task automatic ntsc_lock;
    lines(15); line(LEN, 0);
    lines(14); line(LEN, 0);
  endtask

  initial begin
    #12;
    check("rst_line_len", line_len, 0);
    check("rst_field_lines", field_lines, 0);
    check("rst_field_id", field_id, 0);
    check("rst_pal", pal_mode, 0);
    check("rst_480i", n64_480i, 0);
    check("rst_tv", timing_valid, 0);
    check("rst_nf", new_field, 0);
    nVRST_Tx = 1'b1;
    @(posedge VCLK); #1;

    // NTSC-like 240p: 13 samples/line, 15 lines, vsync coincident with hsync
    lines(15); line(LEN, 0);
    check("ntsc_v1_tv", vf_tv, 0);
    check("ntsc_v1_fl", vf_fl, 15);
    lines(14); line(LEN, 0);
    check("ntsc_v2_tv", vf_tv, 1);
    check("ntsc_v2_fl", vf_fl, 15);
    check("ntsc_v2_pal", vf_pal, 0);
    check("ntsc_v2_480i", vf_i, 0);
    check("ntsc_line_len", line_len, 13);
    lines(14); line(LEN, 0);
    check("ntsc_v3_tv", vf_tv, 1);
    check("ntsc_v3_fid", vf_fid, 0);
    check("ntsc_nf_width", nf_width, 1);

    // one-sample jitter keeps lock, a 3-sample jump drops it
    lines(3); line(14, -1); line(LEN, -1);
    check("jit1_tv", timing_valid, 1);
    check("jit1_len", line_len, 14);
    line(16, -1); line(LEN, -1);
    check("jit3_tv", timing_valid, 0);
    check("jit3_len", line_len, 16);

    // asynchronous reset mid-field, then relock
    lines(2);
    #3 nVRST_Tx = 1'b0;
    #2;
    check("amid_line_len", line_len, 0);
    check("amid_field_lines", field_lines, 0);
    check("amid_tv", timing_valid, 0);
    #2 nVRST_Tx = 1'b1;
    @(posedge VCLK); #1;
    ntsc_lock();
    check("relock_tv", timing_valid, 1);
    check("relock_fl", field_lines, 15);

    // short field of 5 lines
    lines(4); line(LEN, 0);
    check("short_tv", vf_tv, 0);
    check("short_fl", vf_fl, 5);
    lines(14); line(LEN, 0);
    check("short_good1_tv", vf_tv, 0);
    lines(14); line(LEN, 0);
    check("short_good2_tv", vf_tv, 1);

    // PAL-like 480i: fields of 19 and 20 lines, odd vsync at hcnt 6 of a 13-sample line
    do_reset();
    lines(20); line(LEN, 0);
    check("pal_v1_tv", vf_tv, 0);
    check("pal_v1_fid", vf_fid, 0);
    lines(17); line(LEN, 7);
    check("pal_v2_tv", vf_tv, 1);
    check("pal_v2_fl", vf_fl, 19);
    check("pal_v2_fid", vf_fid, 1);
    check("pal_v2_pal", vf_pal, 1);
    check("pal_v2_480i", vf_i, 0);
    lines(20); line(LEN, 0);
    check("pal_v3_fl", vf_fl, 20);
    check("pal_v3_fid", vf_fid, 0);
    check("pal_v3_480i", vf_i, 1);
    lines(17); line(LEN, 7);
    check("pal_v4_fl", vf_fl, 19);
    check("pal_v4_fid", vf_fid, 1);
    check("pal_v4_480i", vf_i, 1);
    check("pal_v4_pal", vf_pal, 1);

    // hsync suppressed: lock lost at the sample where hcnt reaches 100
    smp(1'b1, 1'b0);
    repeat (99) smp(1'b1, 1'b1);
    check("hto_pre_tv", timing_valid, 1);
    smp(1'b1, 1'b1);
    check("hto_tv", timing_valid, 0);
    check("hto_pal_held", pal_mode, 1);
    check("hto_480i_held", n64_480i, 1);

    // sparse strobe: one sample every 4 cycles
    do_reset();
    gap = 4;
    nf_cnt = 0;
    ntsc_lock();
    check("sparse_len", line_len, 13);
    check("sparse_tv", timing_valid, 1);
    check("sparse_nf_width", nf_width, 1);
    check("sparse_nf_cnt", nf_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
